// File: rtl/call_pkg.sv
// Shared types and helpers for the multi-station call light system.
// State encoding, width helpers and a population count used by the top level.
package call_pkg;

  typedef enum logic {IDLE, OFFER} state_t;

  // Upper bound on the number of stations; sizes the popcount argument.
  localparam int MAX_CH = 32;
  localparam int MAX_PC_W = $clog2(MAX_CH + 1);

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int cnt_w(input int n);
    return $clog2(n + 1);
  endfunction

  function automatic logic [MAX_PC_W-1:0] popcount(input logic [MAX_CH-1:0] v);
    logic [MAX_PC_W-1:0] s;
    s = '0;
    for (int i = 0; i < MAX_CH; i++) begin
      s = s + MAX_PC_W'(v[i]);
    end
    return s;
  endfunction

endpackage

// File: rtl/call_rr_arbiter.sv
// Combinational round-robin picker: first set request strictly after last_grant,
// wrapping from N_CH-1 back to 0.
module call_rr_arbiter #(
  parameter int N_CH = 4,
  localparam int CH_W = $clog2(N_CH)
) (
  input  logic [N_CH-1:0] req,
  input  logic [CH_W-1:0] last_grant,
  output logic [N_CH-1:0] grant,
  output logic [CH_W-1:0] grant_idx,
  output logic            any_req
);

  always_comb begin
    logic            found;
    logic [CH_W-1:0] sel;
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    sel       = '0;
    for (int k = 1; k <= N_CH; k++) begin
      sel = CH_W'((int'(last_grant) + k) % N_CH);
      if (!found && req[sel]) begin
        found      = 1'b1;
        grant[sel] = 1'b1;
        grant_idx  = sel;
      end
    end
  end

  assign any_req = |req;

endmodule

// File: rtl/call_system_multi.sv
// N_CH call stations with latched lights and a round-robin valid/ready server.
// Optional CALL_TIMEOUT_EN adds per-channel wait counters that prioritise urgent channels.
module call_system_multi
  import call_pkg::*;
#(
  parameter int N_CH = 4,
  parameter int TIMEOUT_CYCLES = 1000,
  localparam int CH_W = $clog2(N_CH),
  localparam int PC_W = $clog2(N_CH + 1)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N_CH-1:0] call,
  input  logic [N_CH-1:0] cancel,
  output logic [N_CH-1:0] light_state,
  output logic            serve_valid,
  output logic [CH_W-1:0] serve_ch,
  input  logic            serve_ready,
  output logic [PC_W-1:0] pending_count,
  output logic [N_CH-1:0] urgent
);

  state_t          state_reg, state_next;
  logic [N_CH-1:0] light_reg, light_next, clr, req_mask, grant_oh, urgent_vec;
  logic            serve_valid_reg, serve_valid_next;
  logic [CH_W-1:0] serve_ch_reg, serve_ch_next;
  logic [CH_W-1:0] last_grant_reg, last_grant_next;
  logic [CH_W-1:0] grant_idx;
  logic [PC_W-1:0] pending_count_reg;
  logic            any_req, handshake;

  assign handshake = serve_valid_reg & serve_ready;

  // A fresh call on the same edge always wins over cancel and service.
  for (genvar gi = 0; gi < N_CH; gi++) begin : g_light
    assign clr[gi]        = handshake && (serve_ch_reg == CH_W'(gi));
    assign light_next[gi] = call[gi] | (light_reg[gi] & ~cancel[gi] & ~clr[gi]);
  end

`ifdef CALL_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

  for (genvar gi = 0; gi < N_CH; gi++) begin : g_timeout
    logic [TO_W-1:0] wait_cnt_reg;

    always_ff @(posedge clk) begin
      if (!rst_n || !light_reg[gi]) begin
        wait_cnt_reg <= '0;
      end else if (wait_cnt_reg != TO_W'(TIMEOUT_CYCLES)) begin
        wait_cnt_reg <= wait_cnt_reg + 1'b1;
      end
    end

    assign urgent_vec[gi] = light_reg[gi] && (wait_cnt_reg == TO_W'(TIMEOUT_CYCLES));
  end

  assign req_mask = (|urgent_vec) ? urgent_vec : light_reg;
`else
  assign urgent_vec = '0;
  assign req_mask   = light_reg;
`endif

  call_rr_arbiter #(.N_CH(N_CH)) u_arb (
    .req        (req_mask),
    .last_grant (last_grant_reg),
    .grant      (grant_oh),
    .grant_idx  (grant_idx),
    .any_req    (any_req)
  );

  always_comb begin
    state_next       = state_reg;
    serve_valid_next = serve_valid_reg;
    serve_ch_next    = serve_ch_reg;
    last_grant_next  = last_grant_reg;
    case (state_reg)
      IDLE: begin
        if (any_req && (grant_oh != '0)) begin
          state_next       = OFFER;
          serve_valid_next = 1'b1;
          serve_ch_next    = grant_idx;
        end
      end
      OFFER: begin
        if (serve_ready) begin
          state_next       = IDLE;
          serve_valid_next = 1'b0;
          last_grant_next  = serve_ch_reg;
        end else if (cancel[serve_ch_reg] && !call[serve_ch_reg]) begin
          // Withdrawn offers do not advance the round-robin pointer.
          state_next       = IDLE;
          serve_valid_next = 1'b0;
        end
      end
      default: begin
        state_next       = IDLE;
        serve_valid_next = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg         <= IDLE;
      light_reg         <= '0;
      serve_valid_reg   <= 1'b0;
      serve_ch_reg      <= '0;
      last_grant_reg    <= CH_W'(N_CH - 1);
      pending_count_reg <= '0;
    end else begin
      state_reg         <= state_next;
      light_reg         <= light_next;
      serve_valid_reg   <= serve_valid_next;
      serve_ch_reg      <= serve_ch_next;
      last_grant_reg    <= last_grant_next;
      pending_count_reg <= PC_W'(popcount(MAX_CH'(light_next)));
    end
  end

  assign light_state   = light_reg;
  assign serve_valid   = serve_valid_reg;
  assign serve_ch      = serve_ch_reg;
  assign pending_count = pending_count_reg;
  assign urgent        = urgent_vec;

endmodule

// File: tb/tb_call_system_multi.sv
// Bench for call_system_multi: directed vector table, then random traffic vs. a reference model.
// Builds with or without CALL_TIMEOUT_EN; the model follows the same switch.
module tb_call_system_multi;

  localparam int N  = 4;
  localparam int TO = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] call = '0;
  logic [3:0] cancel = '0;
  logic       serve_ready = 1'b0;
  logic [3:0] light_state;
  logic       serve_valid;
  logic [1:0] serve_ch;
  logic [2:0] pending_count;
  logic [3:0] urgent;

  int checks = 0;
  int errors = 0;

  call_system_multi #(.N_CH(N), .TIMEOUT_CYCLES(TO)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .call          (call),
    .cancel        (cancel),
    .light_state   (light_state),
    .serve_valid   (serve_valid),
    .serve_ch      (serve_ch),
    .serve_ready   (serve_ready),
    .pending_count (pending_count),
    .urgent        (urgent)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit       r;
    bit [3:0] c;
    bit [3:0] x;
    bit       rdy;
    bit [3:0] light;
    bit       valid;
    int       ch;
    int       cnt;
  } vec_t;

  vec_t vt[$];

  task automatic add(input bit r, input bit [3:0] c, input bit [3:0] x, input bit rdy,
                     input bit [3:0] l, input bit v, input int ch, input int cnt);
    vec_t e;
    e.r = r; e.c = c; e.x = x; e.rdy = rdy;
    e.light = l; e.valid = v; e.ch = ch; e.cnt = cnt;
    vt.push_back(e);
  endtask

  task automatic chk(input string name, input int idx, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s at %0d: got %0d expected %0d", name, idx, got, exp);
    end
  endtask

  // Reference model: lights, current offer, pointer and the cycle each light came on.
  bit [3:0] m_lit;
  bit       m_valid;
  int       m_ch;
  int       m_last;
  int       m_cyc;
  int       m_since[N];

  function automatic bit [3:0] m_urgent();
    bit [3:0] u;
    u = '0;
`ifdef CALL_TIMEOUT_EN
    for (int i = 0; i < N; i++) u[i] = m_lit[i] && ((m_cyc - m_since[i]) >= TO);
`endif
    return u;
  endfunction

  task automatic model_step(input bit r, input bit [3:0] c, input bit [3:0] x, input bit rdy);
    bit [3:0] nl, cand, urg;
    bit       hs, found;
    int       j;
    if (!r) begin
      m_lit = '0; m_valid = 0; m_ch = 0; m_last = N - 1;
      m_cyc++;
      return;
    end
    urg  = m_urgent();
    cand = (urg != 0) ? urg : m_lit;
    hs   = m_valid && rdy;
    for (int i = 0; i < N; i++) nl[i] = c[i] | (m_lit[i] & ~x[i] & ~(hs && m_ch == i));
    if (!m_valid) begin
      found = 0;
      for (int k = 1; k <= N; k++) begin
        j = (m_last + k) % N;
        if (!found && cand[j]) begin
          found = 1; m_valid = 1; m_ch = j;
        end
      end
    end else if (rdy) begin
      m_last = m_ch; m_valid = 0;
    end else if (x[m_ch] && !c[m_ch]) begin
      m_valid = 0;
    end
    m_cyc++;
    for (int i = 0; i < N; i++) if (nl[i] && !m_lit[i]) m_since[i] = m_cyc;
    m_lit = nl;
  endtask

  initial begin
    //  rst call     cancel   rdy  light    v  ch cnt
    add(0, 4'b0000, 4'b0000, 1, 4'b0000, 0, 0, 0);
    add(1, 4'b0100, 4'b0000, 1, 4'b0100, 0, 0, 1);
    add(1, 4'b0000, 4'b0000, 1, 4'b0100, 1, 2, 1);
    add(1, 4'b0000, 4'b0000, 1, 4'b0000, 0, 0, 0);
    add(1, 4'b0000, 4'b0000, 1, 4'b0000, 0, 0, 0);
    add(0, 4'b0000, 4'b0000, 1, 4'b0000, 0, 0, 0);
    add(1, 4'b1011, 4'b0000, 1, 4'b1011, 0, 0, 3);
    add(1, 4'b0000, 4'b0000, 1, 4'b1011, 1, 0, 3);
    add(1, 4'b0000, 4'b0000, 1, 4'b1010, 0, 0, 2);
    add(1, 4'b0000, 4'b0000, 1, 4'b1010, 1, 1, 2);
    add(1, 4'b0001, 4'b0000, 1, 4'b1001, 0, 0, 2);
    add(1, 4'b0000, 4'b0000, 1, 4'b1001, 1, 3, 2);
    add(1, 4'b0000, 4'b0000, 1, 4'b0001, 0, 0, 1);
    add(1, 4'b0000, 4'b0000, 1, 4'b0001, 1, 0, 1);
    add(1, 4'b0000, 4'b0000, 1, 4'b0000, 0, 0, 0);
    add(1, 4'b0010, 4'b0000, 0, 4'b0010, 0, 0, 1);
    add(1, 4'b0000, 4'b0000, 0, 4'b0010, 1, 1, 1);
    add(1, 4'b0000, 4'b0000, 0, 4'b0010, 1, 1, 1);
    add(1, 4'b0000, 4'b0010, 0, 4'b0000, 0, 0, 0);
    add(1, 4'b0110, 4'b0000, 0, 4'b0110, 0, 0, 2);
    add(1, 4'b0000, 4'b0000, 0, 4'b0110, 1, 1, 2);
    add(1, 4'b0100, 4'b0100, 0, 4'b0110, 1, 1, 2);
    add(1, 4'b0010, 4'b0000, 1, 4'b0110, 0, 0, 2);
    add(1, 4'b0000, 4'b0000, 0, 4'b0110, 1, 2, 2);
    add(1, 4'b0000, 4'b0000, 1, 4'b0010, 0, 0, 1);
    add(1, 4'b0000, 4'b0000, 0, 4'b0010, 1, 1, 1);
    add(1, 4'b0000, 4'b0000, 1, 4'b0000, 0, 0, 0);
    add(1, 4'b1000, 4'b0000, 0, 4'b1000, 0, 0, 1);
    add(1, 4'b0000, 4'b0000, 0, 4'b1000, 1, 3, 1);
    add(0, 4'b0000, 4'b0000, 0, 4'b0000, 0, 0, 0);
    add(1, 4'b1001, 4'b0000, 0, 4'b1001, 0, 0, 2);
    add(1, 4'b0000, 4'b0000, 1, 4'b1001, 1, 0, 2);
    add(1, 4'b0000, 4'b0000, 1, 4'b1000, 0, 0, 1);
    add(1, 4'b0000, 4'b0000, 1, 4'b1000, 1, 3, 1);
    add(1, 4'b0000, 4'b0000, 1, 4'b0000, 0, 0, 0);
    add(1, 4'b0100, 4'b0000, 0, 4'b0100, 0, 0, 1);
    add(1, 4'b0000, 4'b0000, 0, 4'b0100, 1, 2, 1);
    add(1, 4'b0000, 4'b0100, 1, 4'b0000, 0, 0, 0);
    add(1, 4'b0101, 4'b0000, 0, 4'b0101, 0, 0, 2);
    add(1, 4'b0000, 4'b0000, 0, 4'b0101, 1, 0, 2);

    @(negedge clk);
    for (int i = 0; i < vt.size(); i++) begin
      rst_n = vt[i].r; call = vt[i].c; cancel = vt[i].x; serve_ready = vt[i].rdy;
      @(negedge clk);
      chk("light", i, int'(light_state), int'(vt[i].light));
      chk("valid", i, int'(serve_valid), int'(vt[i].valid));
      chk("count", i, int'(pending_count), vt[i].cnt);
      if (vt[i].valid || !vt[i].r) chk("ch", i, int'(serve_ch), vt[i].ch);
      $display("vec %0d: rst_n=%0b call=%b cancel=%b rdy=%0b -> light=%b v=%0b ch=%0d cnt=%0d",
               i, vt[i].r, vt[i].c, vt[i].x, vt[i].rdy, light_state, serve_valid, serve_ch,
               pending_count);
    end

    m_cyc = 0;
    for (int i = 0; i < N; i++) m_since[i] = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      bit       r, rdy;
      bit [3:0] c, x;
      r = (cyc == 0) ? 1'b0 : ($urandom_range(0, 299) != 0);
      for (int i = 0; i < N; i++) begin
        c[i] = ($urandom_range(0, 9) == 0);
        x[i] = ($urandom_range(0, 13) == 0);
      end
      rdy = ((cyc % 200) < 60) ? ($urandom_range(0, 9) == 0) : ($urandom_range(0, 1) == 1);
      rst_n = r; call = c; cancel = x; serve_ready = rdy;
      model_step(r, c, x, rdy);
      @(negedge clk);
      chk("rnd_light", cyc, int'(light_state), int'(m_lit));
      chk("rnd_valid", cyc, int'(serve_valid), int'(m_valid));
      chk("rnd_count", cyc, int'(pending_count), $countones(m_lit));
      chk("rnd_urgent", cyc, int'(urgent), int'(m_urgent()));
      if (m_valid || !r) chk("rnd_ch", cyc, int'(serve_ch), m_ch);
      if (cyc % 100 == 0)
        $display("rnd %0d: light=%b v=%0b ch=%0d cnt=%0d urg=%b", cyc, light_state,
                 serve_valid, serve_ch, pending_count, urgent);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
